// File: rtl/macro_cmd_queue.sv
// Compute-command FIFO and issue FSM for the compute macro, with a hazard-checked
// pass-through path for external load/store traffic to the macro storage port.
module macro_cmd_queue #(
   parameter int ROW_NUM     = 16,
   parameter int COL_NUM_BIT = 6,
   parameter int DEPTH       = 4,
   parameter int CMD_W       = 7 + 3 * COL_NUM_BIT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ExLdSt_valid,
   output logic                       ExLdSt_ready,
   input  logic [COL_NUM_BIT:0]       ExLdSt_command,
   input  logic [ROW_NUM-1:0]         ExLdSt_wdata,
   output logic                       ExLdSt_rvalid,
   output logic [ROW_NUM-1:0]         ExLdSt_rdata,
   input  logic                       Compute_valid,
   output logic                       Compute_ready,
   input  logic [CMD_W-1:0]           Compute_command,
   output logic                       M_compute_valid,
   input  logic                       M_compute_ready,
   output logic [CMD_W-1:0]           M_compute_command,
   input  logic                       M_done,
   output logic                       M_st_valid,
   output logic                       M_st_we,
   output logic [COL_NUM_BIT-1:0]     M_st_addr,
   output logic [ROW_NUM-1:0]         M_st_wdata,
   input  logic [ROW_NUM-1:0]         M_st_rdata,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     queue_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int OW = 3 * COL_NUM_BIT;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t                 state_q;
   logic                   mcv_q;
   logic                   busy_q;
   logic [OW-1:0]          inflight_q;
   logic [CMD_W-1:0]       mem_q [DEPTH];
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]          count;
   logic                   full, empty, enq, pop;
   logic [CMD_W-1:0]       head;
   logic [DEPTH-1:0]       slot_live;
   logic                   hazard, st_acc;

   logic                   st_valid_q, st_valid_d, st_we_q, st_we_d;
   logic [COL_NUM_BIT-1:0] st_addr_q, st_addr_d;
   logic [ROW_NUM-1:0]     st_wdata_q, st_wdata_d;
   logic                   rvalid_q, rvalid_d;
   logic [ROW_NUM-1:0]     rdata_q, rdata_d;

   // Reads only conflict with a pending destination; writes conflict with any operand.
   function automatic logic ops_hit(input logic [OW-1:0] ops,
                                    input logic [COL_NUM_BIT-1:0] addr,
                                    input logic we);
      logic hit;
      hit = (ops[COL_NUM_BIT-1:0] == addr);
      if (we) begin
         hit = hit || (ops[2*COL_NUM_BIT-1:COL_NUM_BIT] == addr)
                   || (ops[OW-1:2*COL_NUM_BIT] == addr);
      end
      return hit;
   endfunction

   assign count  = wr_ptr_q - rd_ptr_q;
   assign full   = (count == PW'(DEPTH));
   assign empty  = (count == '0);
   assign enq    = Compute_valid && !full;
   assign pop    = (state_q == S_ISSUE) && M_compute_ready;
   assign head   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(enq);
      rd_ptr_d = rd_ptr_q + PW'(pop);
   end

   always_comb begin
      slot_live = '0;
      hazard    = busy_q && ops_hit(inflight_q, ExLdSt_command[COL_NUM_BIT-1:0],
                                    ExLdSt_command[COL_NUM_BIT]);
      for (int i = 0; i < DEPTH; i++) begin
         slot_live[i] = ({1'b0, AW'(i) - rd_ptr_q[AW-1:0]} < count);
         if (slot_live[i] && ops_hit(mem_q[i][OW-1:0], ExLdSt_command[COL_NUM_BIT-1:0],
                                     ExLdSt_command[COL_NUM_BIT])) begin
            hazard = 1'b1;
         end
      end
   end

   assign st_acc = ExLdSt_valid && ExLdSt_ready;

   always_comb begin
      st_valid_d = st_acc;
      st_we_d    = st_acc && ExLdSt_command[COL_NUM_BIT];
      st_addr_d  = st_acc ? ExLdSt_command[COL_NUM_BIT-1:0] : st_addr_q;
      st_wdata_d = st_acc ? ExLdSt_wdata : st_wdata_q;
      rvalid_d   = st_valid_q && !st_we_q;
      rdata_d    = rvalid_d ? M_st_rdata : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         st_valid_q <= 1'b0;
         st_we_q    <= 1'b0;
         st_addr_q  <= '0;
         st_wdata_q <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         st_valid_q <= st_valid_d;
         st_we_q    <= st_we_d;
         st_addr_q  <= st_addr_d;
         st_wdata_q <= st_wdata_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         if (enq) mem_q[wr_ptr_q[AW-1:0]] <= Compute_command;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mcv_q      <= 1'b0;
         busy_q     <= 1'b0;
         inflight_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (!empty) begin
               state_q <= S_ISSUE;
               mcv_q   <= 1'b1;
            end
            S_ISSUE: if (M_compute_ready) begin
               inflight_q <= head[OW-1:0];
               busy_q     <= 1'b1;
               mcv_q      <= 1'b0;
               state_q    <= S_WAIT;
            end
            S_WAIT: if (M_done) begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign Compute_ready     = !full;
   assign ExLdSt_ready      = !hazard;
   assign M_compute_valid   = mcv_q;
   assign M_compute_command = mcv_q ? head : '0;
   assign busy              = busy_q;
   assign queue_count       = count;
   assign M_st_valid        = st_valid_q;
   assign M_st_we           = st_we_q;
   assign M_st_addr         = st_addr_q;
   assign M_st_wdata        = st_wdata_q;
   assign ExLdSt_rvalid     = rvalid_q;
   assign ExLdSt_rdata      = rdata_q;
endmodule

// File: tb/tb_macro_cmd_queue.sv
// Directed bench for macro_cmd_queue: load/store timing, issue flow, hazards,
// full/wrap ordering, same-cycle ordering and mid-operation reset.
module tb_macro_cmd_queue;
   localparam int ROW_NUM = 16;
   localparam int CB      = 6;
   localparam int CMD_W   = 25;

   logic               clk = 1'b0;
   logic               rst;
   logic               ExLdSt_valid, ExLdSt_ready;
   logic [CB:0]        ExLdSt_command;
   logic [15:0]        ExLdSt_wdata;
   logic               ExLdSt_rvalid;
   logic [15:0]        ExLdSt_rdata;
   logic               Compute_valid, Compute_ready;
   logic [CMD_W-1:0]   Compute_command;
   logic               M_compute_valid, M_compute_ready;
   logic [CMD_W-1:0]   M_compute_command;
   logic               M_done;
   logic               M_st_valid, M_st_we;
   logic [CB-1:0]      M_st_addr;
   logic [15:0]        M_st_wdata, M_st_rdata;
   logic               busy;
   logic [2:0]         queue_count;

   logic [15:0]        tbmem [64];
   int                 checks = 0;
   int                 errors = 0;

   localparam logic [CMD_W-1:0] AND_CMD = 25'b0_010_010_000001_000010_000011;
   localparam logic [CMD_W-1:0] MUL_CMD = {1'b0, 3'b011, 3'b000, 6'd1, 6'd5, 6'd6};

   macro_cmd_queue #(.ROW_NUM(ROW_NUM), .COL_NUM_BIT(CB), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .ExLdSt_valid(ExLdSt_valid), .ExLdSt_ready(ExLdSt_ready),
      .ExLdSt_command(ExLdSt_command), .ExLdSt_wdata(ExLdSt_wdata),
      .ExLdSt_rvalid(ExLdSt_rvalid), .ExLdSt_rdata(ExLdSt_rdata),
      .Compute_valid(Compute_valid), .Compute_ready(Compute_ready),
      .Compute_command(Compute_command),
      .M_compute_valid(M_compute_valid), .M_compute_ready(M_compute_ready),
      .M_compute_command(M_compute_command), .M_done(M_done),
      .M_st_valid(M_st_valid), .M_st_we(M_st_we), .M_st_addr(M_st_addr),
      .M_st_wdata(M_st_wdata), .M_st_rdata(M_st_rdata),
      .busy(busy), .queue_count(queue_count)
   );

   always #5 clk = ~clk;

   // Storage macro model: combinational read, write on strobe edge.
   always @(posedge clk) if (M_st_valid && M_st_we) tbmem[M_st_addr] <= M_st_wdata;
   assign M_st_rdata = tbmem[M_st_addr];

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [CMD_W-1:0] cmdn(input int n);
      return {1'b0, 3'd1, 3'd2, 6'(n + 40), 6'(n + 20), 6'(n + 8)};
   endfunction

   initial begin
      int n_in, n_out, iter;
      logic issued, acc;

      rst = 1'b1; ExLdSt_valid = 0; ExLdSt_command = '0; ExLdSt_wdata = '0;
      Compute_valid = 0; Compute_command = '0; M_compute_ready = 0; M_done = 0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_cq_ready", 32'(Compute_ready), 1);
      chk("rst_ls_ready", 32'(ExLdSt_ready), 1);
      chk("rst_count", 32'(queue_count), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mcv", 32'(M_compute_valid), 0);
      chk("rst_mcmd", 32'(M_compute_command), 0);
      chk("rst_st_valid", 32'(M_st_valid), 0);
      chk("rst_rvalid", 32'(ExLdSt_rvalid), 0);

      // store 0xaa55 to col 1, then read it back
      ExLdSt_valid = 1; ExLdSt_command = {1'b1, 6'd1}; ExLdSt_wdata = 16'haa55;
      #1 chk("st_ready", 32'(ExLdSt_ready), 1);
      step();
      chk("st_strobe", 32'({M_st_valid, M_st_we}), 32'b11);
      chk("st_addr", 32'(M_st_addr), 1);
      chk("st_wdata", 32'(M_st_wdata), 32'haa55);
      ExLdSt_command = {1'b0, 6'd1};
      step();
      ExLdSt_valid = 0;
      chk("rd_strobe", 32'({M_st_valid, M_st_we}), 32'b10);
      chk("rd_rvalid_early", 32'(ExLdSt_rvalid), 0);
      step();
      chk("rd_rvalid", 32'(ExLdSt_rvalid), 1);
      chk("rd_rdata", 32'(ExLdSt_rdata), 32'haa55);
      chk("st_idle", 32'(M_st_valid), 0);
      step();
      chk("rd_rvalid_pulse", 32'(ExLdSt_rvalid), 0);
      chk("rd_rdata_hold", 32'(ExLdSt_rdata), 32'haa55);

      // AND issue with hazards while in flight
      M_compute_ready = 1; Compute_valid = 1; Compute_command = AND_CMD;
      step();
      Compute_valid = 0;
      chk("and_count1", 32'(queue_count), 1);
      chk("and_mcv_early", 32'(M_compute_valid), 0);
      step();
      chk("and_mcv", 32'(M_compute_valid), 1);
      chk("and_mcmd", 32'(M_compute_command), 32'(AND_CMD));
      step();
      chk("and_busy1", 32'(busy), 1);
      chk("and_count0", 32'(queue_count), 0);
      chk("and_mcv_off", 32'(M_compute_valid), 0);
      ExLdSt_valid = 1; ExLdSt_command = {1'b0, 6'd3};
      #1 chk("hz_rd_rd", 32'(ExLdSt_ready), 0);
      ExLdSt_command = {1'b0, 6'd1};
      #1 chk("hz_rd_rs1", 32'(ExLdSt_ready), 1);
      step();
      chk("and_busy2", 32'(busy), 1);
      chk("hz_rd_rs1_strobe", 32'({M_st_valid, M_st_we, 1'b0, M_st_addr}), {2'b10, 1'b0, 6'd1});
      ExLdSt_command = {1'b1, 6'd2};
      #1 chk("hz_wr_rs2", 32'(ExLdSt_ready), 0);
      ExLdSt_command = {1'b1, 6'd1};
      #1 chk("hz_wr_rs1", 32'(ExLdSt_ready), 0);
      ExLdSt_command = {1'b1, 6'd3};
      #1 chk("hz_wr_rd", 32'(ExLdSt_ready), 0);
      ExLdSt_command = {1'b0, 6'd3};
      step();
      chk("and_busy3", 32'(busy), 1);
      chk("hz_rs1_rvalid", 32'({ExLdSt_rvalid, ExLdSt_rdata}), {1'b1, 16'haa55});
      chk("hz_hold3", 32'(ExLdSt_ready), 0);
      step();
      chk("and_busy4", 32'(busy), 1);
      chk("hz_hold4", 32'(ExLdSt_ready), 0);
      step();
      chk("and_busy5", 32'(busy), 1);
      M_done = 1;
      #1 chk("hz_hold_done", 32'(ExLdSt_ready), 0);
      step();
      M_done = 0;
      chk("and_busy_clr", 32'(busy), 0);
      chk("hz_clear", 32'(ExLdSt_ready), 1);
      step();
      ExLdSt_valid = 0;
      chk("hz_rd3_strobe", 32'({M_st_valid, M_st_addr}), {1'b1, 6'd3});
      step(); step();

      // full queue, then drain through pointer wrap
      M_compute_ready = 0;
      for (int k = 0; k < 4; k++) begin
         Compute_valid = 1; Compute_command = cmdn(k);
         #1 chk("fill_ready", 32'(Compute_ready), 1);
         step();
      end
      Compute_command = cmdn(4);
      #1 chk("full_ready", 32'(Compute_ready), 0);
      chk("full_count", 32'(queue_count), 4);
      step();
      chk("full_count_hold", 32'(queue_count), 4);
      chk("full_head", 32'(M_compute_command), 32'(cmdn(0)));
      M_compute_ready = 1;
      n_in = 4; n_out = 0; iter = 0;
      while (!(n_in == 14 && n_out == 14 && !busy && queue_count == 0) && iter < 300) begin
         Compute_valid = (n_in < 14);
         Compute_command = cmdn(n_in);
         M_done = busy;
         #1;
         issued = M_compute_valid;
         if (issued) chk("drain_order", 32'(M_compute_command), 32'(cmdn(n_out)));
         acc = Compute_valid && Compute_ready;
         step();
         if (acc) n_in++;
         if (issued) n_out++;
         iter++;
      end
      Compute_valid = 0; M_done = 0;
      chk("drain_issued", 32'(n_out), 14);
      chk("drain_count", 32'(queue_count), 0);
      step();

      // same-cycle enqueue and write to an operand column
      Compute_valid = 1; Compute_command = MUL_CMD;
      ExLdSt_valid = 1; ExLdSt_command = {1'b1, 6'd1}; ExLdSt_wdata = 16'h1234;
      #1 chk("same_ls_ready", 32'(ExLdSt_ready), 1);
      step();
      Compute_valid = 0;
      chk("same_strobe", 32'({M_st_valid, M_st_we, 1'b0, M_st_addr}), {2'b11, 1'b0, 6'd1});
      chk("same_wdata", 32'(M_st_wdata), 32'h1234);
      chk("same_mcv_early", 32'(M_compute_valid), 0);
      #1 chk("same_then_stall", 32'(ExLdSt_ready), 0);
      ExLdSt_valid = 0;
      step();
      chk("same_mcv", 32'(M_compute_valid), 1);
      chk("same_mcmd", 32'(M_compute_command), 32'(MUL_CMD));
      step();
      chk("same_busy", 32'(busy), 1);
      M_done = 1;
      step();
      M_done = 0;
      chk("same_done", 32'(busy), 0);

      // reset during WAIT with two entries queued
      for (int k = 0; k < 3; k++) begin
         Compute_valid = 1; Compute_command = cmdn(k);
         step();
      end
      Compute_valid = 0;
      chk("rw_busy", 32'(busy), 1);
      chk("rw_count", 32'(queue_count), 2);
      rst = 1; M_done = 1; ExLdSt_valid = 1; ExLdSt_command = {1'b0, 6'd9};
      step();
      rst = 0; M_done = 0; ExLdSt_valid = 0;
      chk("rw_count0", 32'(queue_count), 0);
      chk("rw_busy0", 32'(busy), 0);
      chk("rw_mcv0", 32'(M_compute_valid), 0);
      chk("rw_st0", 32'(M_st_valid), 0);
      chk("rw_cq_ready", 32'(Compute_ready), 1);
      step();
      chk("rw_rvalid0", 32'(ExLdSt_rvalid), 0);
      M_done = 1;
      step();
      M_done = 0;
      chk("rw_late_done", 32'({busy, M_compute_valid, 1'b0, queue_count}), 0);
      step();
      chk("rw_idle", 32'(M_compute_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
